fetch_sequencer: RTL

Instruction-fetch controller for the single-cycle instruction memory (64-bit byte address in, 32-bit instruction out, combinational read). It owns the program counter, drives the memory address, and captures each fetched word with its PC into a 2-entry buffer. That buffer feeds decode over a valid/ready handshake. It also handles branch redirects, halt/resume and out-of-range fetch faults.

---
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the single-cycle instruction
// memory and queues {pc, instr} pairs in a 2-entry FIFO toward decode.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_adr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED, S_FAULT} state_t;

  localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE) * 64'd4;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_set_fault;
  logic [63:0] r_pc;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_fault;
  logic [31:0] r_retired;
  logic [63:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];

  logic        w_in_range;
  logic        w_pop;
  logic        w_fire;
  logic        w_tail;
  logic [63:0] w_redirect_target;

  assign w_in_range        = (r_pc < MEM_BYTES);
  assign w_pop             = (r_count != 2'd0) & out_ready;
  assign w_fire            = (r_state == S_FETCH) & !redirect_valid & !halt & w_in_range
                             & ((r_count != 2'd2) | w_pop);
  // With two slots, tail is head for count 0 or 2 and the other slot for count 1.
  assign w_tail            = r_head ^ r_count[0];
  assign w_redirect_target = redirect_pc & ~64'h3;

  always_comb begin
    w_state_next = r_state;
    w_set_fault  = 1'b0;
    if (redirect_valid) begin
      w_state_next = halt ? S_HALTED : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:   w_state_next = halt ? S_HALTED : S_FETCH;
        S_FETCH: begin
          if (!w_in_range) begin
            w_state_next = S_FAULT;
            w_set_fault  = 1'b1;
          end else if (halt) begin
            w_state_next = S_HALTED;
          end
        end
        S_HALTED: if (!halt) w_state_next = S_FETCH;
        S_FAULT:  w_state_next = S_FAULT;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_count   <= 2'd0;
      r_head    <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_retired <= r_retired + 32'd1;
        r_head    <= ~r_head;
      end
      if (redirect_valid) begin
        r_pc    <= w_redirect_target;
        r_count <= 2'd0;
        r_fault <= 1'b0;
      end else begin
        if (w_fire) r_pc <= r_pc + 64'd4;
        if (w_fire && !w_pop)      r_count <= r_count + 2'd1;
        else if (!w_fire && w_pop) r_count <= r_count - 2'd1;
        if (w_set_fault) r_fault <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (reset) begin
        r_buf_pc[gi]    <= 64'd0;
        r_buf_instr[gi] <= 32'd0;
      end else if (w_fire && (w_tail == 1'(gi))) begin
        r_buf_pc[gi]    <= r_pc;
        r_buf_instr[gi] <= imem_instr;
      end
    end
  end

  assign imem_adr  = r_pc;
  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_buf_pc[r_head];
  assign out_instr = r_buf_instr[r_head];
  assign fault     = r_fault;
  assign retired   = r_retired;

endmodule
